// File: rtl/ext_sram_pkg.sv
// Shared types and constants for the external SRAM bus controller.
// Holds the bus-cycle state encoding, access-size codes and wait counter width,
// plus the alignment rule used at request acceptance.
package ext_sram_pkg;

   // Bus cycle phases: address latch low (T1), address latch high (T2),
   // wait states (TW), strobe release / read sample (T3).
   typedef enum logic [2:0] {
      IDLE,
      T1,
      T2,
      TW,
      T3
   } state_e;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam int WAIT_W = 4;

   // Size code 3 behaves as a word, so any size with bit 1 set needs 4-byte
   // alignment. Bytes are always aligned.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
      return ((size == SZ_HALF) && a[0]) || (size[1] && (a != 2'b00));
   endfunction

endpackage

// File: rtl/ext_sram_ctrl_if.sv
// Core-side memory request port of the external SRAM controller.
// Ports: valid/rw/size/addr/wdata from the requester; ready/rdata/done/err back.
// ready is high only while the controller is idle; there is no request queue.
interface ext_sram_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              valid;
   logic              ready;
   logic              rw;
   logic [1:0]        size;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic              done;
   logic              err;

   modport master (
      output valid, rw, size, addr, wdata,
      input  ready, rdata, done, err
   );

   modport slave (
      input  valid, rw, size, addr, wdata,
      output ready, rdata, done, err
   );
endinterface

// File: rtl/ext_sram_lane.sv
// Byte-lane steering for the 16-bit multiplexed bus (purely combinational).
// Ports: wdata_i/size_i/a0_i/hi_sel_i -> wr_dat_o, bl_o, bh_o;
//        din_i/size_i/a0_i -> rd_dat_o (zero-extended to 16 bits).
module ext_sram_lane
   import ext_sram_pkg::*;
(
   input  logic [31:0] wdata_i,
   input  logic [1:0]  size_i,
   input  logic        a0_i,
   input  logic        hi_sel_i,
   input  logic [15:0] din_i,
   output logic [15:0] wr_dat_o,
   output logic        bl_o,
   output logic        bh_o,
   output logic [15:0] rd_dat_o
);

   logic is_byte;
   assign is_byte = (size_i == SZ_BYTE);

   always_comb begin
      bl_o = !is_byte || !a0_i;
      bh_o = !is_byte ||  a0_i;

      // A byte is replicated on both halves so either lane carries it.
      if (is_byte) begin
         wr_dat_o = {wdata_i[7:0], wdata_i[7:0]};
      end else if (hi_sel_i) begin
         wr_dat_o = wdata_i[31:16];
      end else begin
         wr_dat_o = wdata_i[15:0];
      end

      if (!is_byte) begin
         rd_dat_o = din_i;
      end else if (a0_i) begin
         rd_dat_o = {8'h00, din_i[15:8]};
      end else begin
         rd_dat_o = {8'h00, din_i[7:0]};
      end
   end

endmodule

// File: rtl/ext_sram_ctrl.sv
// Multiplexed 16-bit address/data SRAM bus controller with wait states and word splitting.
// Ports: clk/rst, core request port (req), SRAM bus din/dout/isout and strobes we/oe/ale0/ale1/ble/bhe.
// Latency: 3+WAIT_STATES cycles per transfer (+1 for done); ready drops while busy, no queueing.
module ext_sram_ctrl
   import ext_sram_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int WAIT_STATES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   ext_sram_ctrl_if.slave       req,
   input  logic [15:0]          din,
   output logic [15:0]          dout,
   output logic                 isout,
   output logic                 we,
   output logic                 oe,
   output logic                 ale0,
   output logic                 ale1,
   output logic                 ble,
   output logic                 bhe
);

   // TW is entered with the counter preloaded so that exactly WAIT_STATES
   // TW cycles elapse before T3.
   localparam logic [WAIT_W-1:0] WAIT_LD =
      (WAIT_STATES > 0) ? WAIT_W'(WAIT_STATES - 1) : '0;

   state_e              state_q;
   logic [WAIT_W-1:0]   wcnt_q;
   logic                half_q;     // second transfer of a word in progress
   logic [ADDR_W-1:0]   a_q;        // address of the current transfer
   logic                rw_q;
   logic [1:0]          size_q;
   logic [31:0]         wdata_q;
   logic [15:0]         lo_q;       // first half of a word read
   logic [31:0]         rdata_q;
   logic                done_q;
   logic                err_q;
   logic [15:0]         dout_q;
   logic                isout_q;
   logic                we_q;
   logic                oe_q;
   logic                ale0_q;
   logic                ale1_q;
   logic                ble_q;
   logic                bhe_q;

   logic                is_word;
   logic                req_mis;
   logic [14:0]         hi_addr;
   logic [15:0]         a_mid_d;    // A[16:1] of the second word transfer
   logic [15:0]         wr_dat;
   logic [15:0]         rd_dat;
   logic                bl;
   logic                bh;

   assign is_word = size_q[1];
   assign req_mis = misaligned(req.size, req.addr[1:0]);
   assign hi_addr = 15'(a_q >> 17);
   assign a_mid_d = a_q[16:1] + 16'd1;

   ext_sram_lane u_lane (
      .wdata_i  (wdata_q),
      .size_i   (size_q),
      .a0_i     (a_q[0]),
      .hi_sel_i (half_q),
      .din_i    (din),
      .wr_dat_o (wr_dat),
      .bl_o     (bl),
      .bh_o     (bh),
      .rd_dat_o (rd_dat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         half_q  <= 1'b0;
         a_q     <= '0;
         rw_q    <= 1'b0;
         size_q  <= SZ_BYTE;
         wdata_q <= '0;
         lo_q    <= '0;
         rdata_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         dout_q  <= '0;
         isout_q <= 1'b0;
         we_q    <= 1'b0;
         oe_q    <= 1'b0;
         ale0_q  <= 1'b0;
         ale1_q  <= 1'b0;
         ble_q   <= 1'b0;
         bhe_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;

         case (state_q)
            IDLE: begin
               if (req.valid) begin
                  a_q     <= req.addr;
                  rw_q    <= req.rw;
                  size_q  <= req.size;
                  wdata_q <= req.wdata;
                  if (req_mis) begin
                     // Rejected without touching the bus; stay idle.
                     done_q  <= 1'b1;
                     err_q   <= 1'b1;
                     rdata_q <= '0;
                  end else begin
                     state_q <= T1;
                     half_q  <= 1'b0;
                     ale0_q  <= 1'b1;
                     isout_q <= 1'b1;
                     dout_q  <= req.addr[16:1];
                  end
               end
            end

            T1: begin
               state_q <= T2;
               ale0_q  <= 1'b0;
               ale1_q  <= 1'b1;
               dout_q  <= {bl, hi_addr};
               we_q    <= rw_q;
               oe_q    <= !rw_q;
               ble_q   <= bl;
            end

            T2: begin
               ale1_q <= 1'b0;
               if (WAIT_STATES == 0) begin
                  state_q <= T3;
                  isout_q <= 1'b0;
                  we_q    <= 1'b0;
                  oe_q    <= 1'b0;
                  ble_q   <= 1'b0;
                  bhe_q   <= 1'b0;
                  dout_q  <= '0;
               end else begin
                  // Data phase: writes drive the steered lane data, reads
                  // release the bus to the SRAM.
                  state_q <= TW;
                  wcnt_q  <= WAIT_LD;
                  bhe_q   <= bh;
                  isout_q <= rw_q;
                  dout_q  <= rw_q ? wr_dat : 16'h0000;
               end
            end

            TW: begin
               if (wcnt_q != '0) begin
                  wcnt_q <= wcnt_q - WAIT_W'(1);
               end else begin
                  state_q <= T3;
                  isout_q <= 1'b0;
                  we_q    <= 1'b0;
                  oe_q    <= 1'b0;
                  ble_q   <= 1'b0;
                  bhe_q   <= 1'b0;
                  dout_q  <= '0;
               end
            end

            T3: begin
               // din is sampled here, on the edge leaving T3.
               if (is_word && !half_q) begin
                  lo_q    <= din;
                  half_q  <= 1'b1;
                  a_q     <= a_q + ADDR_W'(2);
                  state_q <= T1;
                  ale0_q  <= 1'b1;
                  isout_q <= 1'b1;
                  dout_q  <= a_mid_d;
               end else begin
                  state_q <= IDLE;
                  half_q  <= 1'b0;
                  done_q  <= 1'b1;
                  if (rw_q) begin
                     rdata_q <= '0;
                  end else if (is_word) begin
                     rdata_q <= {din, lo_q};
                  end else begin
                     rdata_q <= {16'h0000, rd_dat};
                  end
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign req.ready = (state_q == IDLE);
   assign req.rdata = rdata_q;
   assign req.done  = done_q;
   assign req.err   = err_q;

   assign dout  = dout_q;
   assign isout = isout_q;
   assign we    = we_q;
   assign oe    = oe_q;
   assign ale0  = ale0_q;
   assign ale1  = ale1_q;
   assign ble   = ble_q;
   assign bhe   = bhe_q;

endmodule

// File: tb/tb_ext_sram_ctrl.sv
// Bench for ext_sram_ctrl: three instances with WAIT_STATES = 0, 1, 2 share stimulus.
// Requests go through a vector table and a done-side scoreboard; bus cycles are
// compared against per-cycle expected strobe/dout traces.
`timescale 1ns/1ps
module tb_ext_sram_ctrl;
   import ext_sram_pkg::*;

   localparam int AW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic [2:0]    vld = 3'b000;
   logic          rw_s = 1'b0;
   logic [1:0]    size_s = 2'd0;
   logic [AW-1:0] addr_s = '0;
   logic [31:0]   wdata_s = '0;
   logic [15:0]   din_lo = '0;
   logic [15:0]   din_hi = '0;
   logic [15:0]   din_s;

   logic          rdy_a   [3];
   logic          done_a  [3];
   logic          err_a   [3];
   logic [31:0]   rdata_a [3];
   logic [15:0]   dout_a  [3];
   logic          isout_a [3];
   logic          we_a    [3];
   logic          oe_a    [3];
   logic          ale0_a  [3];
   logic          ale1_a  [3];
   logic          ble_a   [3];
   logic          bhe_a   [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      ext_sram_ctrl_if #(.ADDR_W(AW)) bus ();
      assign bus.valid  = vld[g];
      assign bus.rw     = rw_s;
      assign bus.size   = size_s;
      assign bus.addr   = addr_s;
      assign bus.wdata  = wdata_s;
      assign rdy_a[g]   = bus.ready;
      assign done_a[g]  = bus.done;
      assign err_a[g]   = bus.err;
      assign rdata_a[g] = bus.rdata;

      ext_sram_ctrl #(.ADDR_W(AW), .WAIT_STATES(g)) dut (
         .clk   (clk),
         .rst   (rst),
         .req   (bus.slave),
         .din   (din_s),
         .dout  (dout_a[g]),
         .isout (isout_a[g]),
         .we    (we_a[g]),
         .oe    (oe_a[g]),
         .ale0  (ale0_a[g]),
         .ale1  (ale1_a[g]),
         .ble   (ble_a[g]),
         .bhe   (bhe_a[g])
      );
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   // Cycle counter and a simple SRAM data model: the n-th ale0 pulse of the
   // current request selects which din half the SRAM returns.
   int cyc = 0;
   int cur = 0;
   int ale_cnt = 0;
   int ale_base = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (ale0_a[cur]) ale_cnt <= ale_cnt + 1;
   assign din_s = ((ale_cnt - ale_base) >= 2) ? din_hi : din_lo;

   typedef struct {
      logic [31:0] rdata;
      logic        chk;
      logic        err;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   acq[$];

   always @(negedge clk) begin
      if (!rst && done_a[cur]) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'(done_a[cur]), 32'h0);
         end else begin
            exp_t e;
            int   a;
            e = sb.pop_front();
            a = acq.pop_front();
            check("done_latency", 32'(cyc - a + 1), 32'(e.lat));
            check("done_err", 32'(err_a[cur]), 32'(e.err));
            if (e.chk) check("done_rdata", rdata_a[cur], e.rdata);
         end
      end
   end

   // Caller is at a negedge; returns #1 after the acceptance edge (cycle 1).
   task automatic issue(input int k, input logic r, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [15:0] lo, input logic [15:0] hi, input exp_t e);
      check("ready_at_issue", 32'(rdy_a[k]), 32'h1);
      cur      = k;
      rw_s     = r;
      size_s   = sz;
      addr_s   = a;
      wdata_s  = wd;
      din_lo   = lo;
      din_hi   = hi;
      ale_base = ale_cnt;
      sb.push_back(e);
      vld[k]   = 1'b1;
      @(posedge clk);
      #1;
      vld[k]   = 1'b0;
      acq.push_back(cyc);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         n_chk++;
         n_err++;
         $display("FAIL done_timeout: %0d requests outstanding, required 0", sb.size());
         sb.delete();
         acq.delete();
      end
   endtask

   // {ready, ale0, ale1, isout, we, oe, ble, bhe} over dout
   function automatic logic [23:0] busv(input int k);
      return {rdy_a[k], ale0_a[k], ale1_a[k], isout_a[k], we_a[k], oe_a[k],
              ble_a[k], bhe_a[k], dout_a[k]};
   endfunction

   function automatic logic [23:0] mk(input logic [7:0] f, input logic [15:0] d);
      return {f, d};
   endfunction

   logic [23:0] tr[$];

   task automatic run_trace(input int k, input string nm, input logic poke);
      for (int c = 0; c < tr.size(); c++) begin
         @(negedge clk);
         check($sformatf("%s_c%0d", nm, c + 1), 32'(busv(k)), 32'(tr[c]));
         // A request presented while busy must be dropped.
         if (poke && c == 1) vld[k] = 1'b1;
         if (poke && c == 2) vld[k] = 1'b0;
      end
   endtask

   typedef struct {
      int          k;
      logic        rw;
      logic [1:0]  sz;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [15:0] lo;
      logic [15:0] hi;
      logic        err;
      logic        chk;
      logic [31:0] rdata;
      int          lat;
   } vec_t;

   vec_t vt[14];

   initial begin
      int   n;
      logic seen;

      vt[0]  = '{1, 1'b0, SZ_HALF, 32'h0002_4680, 32'h0,         16'hBEEF, 16'h0000, 1'b0, 1'b1, 32'h0000_BEEF, 5};
      vt[1]  = '{1, 1'b1, SZ_BYTE, 32'h0000_0011, 32'h0000_005A, 16'h0000, 16'h0000, 1'b0, 1'b0, 32'h0,         5};
      vt[2]  = '{2, 1'b1, SZ_WORD, 32'h0000_0100, 32'h1234_5678, 16'h0000, 16'h0000, 1'b0, 1'b0, 32'h0,         11};
      vt[3]  = '{1, 1'b0, SZ_WORD, 32'h0000_0102, 32'h0,         16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 32'h0,         1};
      vt[4]  = '{1, 1'b0, SZ_BYTE, 32'h0000_0003, 32'h0,         16'hA55A, 16'h0000, 1'b0, 1'b1, 32'h0000_00A5, 5};
      vt[5]  = '{1, 1'b0, SZ_BYTE, 32'h0000_0002, 32'h0,         16'hA55A, 16'h0000, 1'b0, 1'b1, 32'h0000_005A, 5};
      vt[6]  = '{2, 1'b0, SZ_WORD, 32'h0000_0200, 32'h0,         16'h1111, 16'h2222, 1'b0, 1'b1, 32'h2222_1111, 11};
      vt[7]  = '{0, 1'b0, SZ_HALF, 32'h0000_0006, 32'h0,         16'h7777, 16'h0000, 1'b0, 1'b1, 32'h0000_7777, 4};
      vt[8]  = '{0, 1'b0, SZ_HALF, 32'h0000_0005, 32'h0,         16'h7777, 16'h0000, 1'b1, 1'b1, 32'h0,         1};
      vt[9]  = '{1, 1'b0, 2'd3,    32'h0000_0010, 32'h0,         16'h0102, 16'h0304, 1'b0, 1'b1, 32'h0304_0102, 9};
      vt[10] = '{0, 1'b1, SZ_HALF, 32'h0000_0008, 32'hCAFE_D00D, 16'h0000, 16'h0000, 1'b0, 1'b0, 32'h0,         4};
      vt[11] = '{1, 1'b1, SZ_WORD, 32'h0000_0001, 32'h0,         16'h0000, 16'h0000, 1'b1, 1'b1, 32'h0,         1};
      vt[12] = '{0, 1'b0, SZ_BYTE, 32'h0000_0001, 32'h0,         16'hC3B4, 16'h0000, 1'b0, 1'b1, 32'h0000_00C3, 4};
      vt[13] = '{2, 1'b0, SZ_BYTE, 32'h0003_FFFF, 32'h0,         16'h9F00, 16'h0000, 1'b0, 1'b1, 32'h0000_009F, 6};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset_bus_w%0d", k), 32'(busv(k)), 32'(mk(8'b1000_0000, 16'h0)));
         check($sformatf("reset_done_err_w%0d", k), {30'h0, done_a[k], err_a[k]}, 32'h0);
         check($sformatf("reset_rdata_w%0d", k), rdata_a[k], 32'h0);
      end
      rst = 1'b0;

      // Table-driven requests
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         issue(vt[i].k, vt[i].rw, vt[i].sz, vt[i].addr, vt[i].wdata, vt[i].lo, vt[i].hi,
               '{vt[i].rdata, vt[i].chk, vt[i].err, vt[i].lat});
         drain(40);
      end
      repeat (3) @(negedge clk);
      check("rdata_hold", rdata_a[2], 32'h0000_009F);

      // Half read bus trace, W=1
      @(negedge clk);
      issue(1, 1'b0, SZ_HALF, 32'h0002_4680, 32'h0, 16'hBEEF, 16'h0, '{32'h0000_BEEF, 1'b1, 1'b0, 5});
      tr = '{mk(8'b0101_0000, 16'h2340), mk(8'b0011_0110, 16'h8001), mk(8'b0000_0111, 16'h0000),
             mk(8'b0000_0000, 16'h0000), mk(8'b1000_0000, 16'h0000)};
      run_trace(1, "hrd", 1'b0);
      drain(20);

      // Byte write bus trace, W=1, with an ignored request while busy
      @(negedge clk);
      issue(1, 1'b1, SZ_BYTE, 32'h0000_0011, 32'h0000_005A, 16'h0, 16'h0, '{32'h0, 1'b0, 1'b0, 5});
      tr = '{mk(8'b0101_0000, 16'h0008), mk(8'b0011_1000, 16'h0000), mk(8'b0001_1001, 16'h5A5A),
             mk(8'b0000_0000, 16'h0000), mk(8'b1000_0000, 16'h0000)};
      run_trace(1, "bwr", 1'b1);
      repeat (4) @(negedge clk);
      drain(20);

      // Word write bus trace, W=2
      @(negedge clk);
      issue(2, 1'b1, SZ_WORD, 32'h0000_0100, 32'h1234_5678, 16'h0, 16'h0, '{32'h0, 1'b0, 1'b0, 11});
      tr = '{mk(8'b0101_0000, 16'h0080), mk(8'b0011_1010, 16'h8000), mk(8'b0001_1011, 16'h5678),
             mk(8'b0001_1011, 16'h5678), mk(8'b0000_0000, 16'h0000), mk(8'b0101_0000, 16'h0081),
             mk(8'b0011_1010, 16'h8000), mk(8'b0001_1011, 16'h1234), mk(8'b0001_1011, 16'h1234),
             mk(8'b0000_0000, 16'h0000), mk(8'b1000_0000, 16'h0000)};
      run_trace(2, "wwr", 1'b0);
      drain(20);

      // Misaligned word read: no bus activity, ready stays high
      @(negedge clk);
      issue(1, 1'b0, SZ_WORD, 32'h0000_0102, 32'h0, 16'hFFFF, 16'hFFFF, '{32'h0, 1'b1, 1'b1, 1});
      tr = '{mk(8'b1000_0000, 16'h0000), mk(8'b1000_0000, 16'h0000)};
      run_trace(1, "mis", 1'b0);
      drain(20);

      // W=0 word read followed back-to-back by a byte read
      @(negedge clk);
      issue(0, 1'b0, SZ_WORD, 32'h0000_0040, 32'h0, 16'hAAAA, 16'hBBBB, '{32'hBBBB_AAAA, 1'b1, 1'b0, 7});
      n = 0;
      while (!done_a[0] && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("b2b_first_done_seen", 32'(done_a[0]), 32'h1);
      issue(0, 1'b0, SZ_BYTE, 32'h0000_0041, 32'h0, 16'h1200, 16'h0, '{32'h0000_0012, 1'b1, 1'b0, 4});
      @(negedge clk);
      check("b2b_t1_follows", 32'(ale0_a[0]), 32'h1);
      drain(20);

      // Reset during TW of a byte write, W=1
      @(negedge clk);
      issue(1, 1'b1, SZ_BYTE, 32'h0000_0020, 32'h0000_0033, 16'h0, 16'h0, '{32'h0, 1'b0, 1'b0, 5});
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("rst_pre_tw_bus", 32'(busv(1)), 32'(mk(8'b0001_1010, 16'h3333)));
      rst = 1'b1;
      @(negedge clk);
      check("rst_bus", 32'(busv(1)), 32'(mk(8'b1000_0000, 16'h0)));
      check("rst_done_err", {30'h0, done_a[1], err_a[1]}, 32'h0);
      check("rst_rdata", rdata_a[1], 32'h0);
      sb.delete();
      acq.delete();
      rst = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         seen = seen | done_a[1];
      end
      check("rst_no_done", 32'(seen), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
